vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA timing core that merges pixel-clock division, horizontal and vertical counting, and sync decode into one block. Resolution, porches, sync polarity and clock ratio are all parameters. It adds registered, aligned outputs and one-cycle line-start and frame-start strobes. It sits between the board clock and the pixel generator, and drives the h_sync/v_sync pins plus the x/y/video_on signals used by pixel logic.

Parameters:
CLK_DIV, 4, board clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of h_sync
VS_POL, 0, asserted level of v_sync
XW, 10, x width; must hold H_TOTAL-1
YW, 10, y width; must hold V_TOTAL-1

Ports:
clk  in  1  board clock
rst_n  in  1  asynchronous active-low reset
pix_en  out  1  one-clk pixel tick
x  out  XW  horizontal count 0..H_TOTAL-1
y  out  YW  vertical count 0..V_TOTAL-1
video_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE
h_sync  out  1  horizontal sync, polarity HS_POL
v_sync  out  1  vertical sync, polarity VS_POL
line_start  out  1  one-clk strobe when x becomes 0
frame_start  out  1  one-clk strobe when (x,y) becomes (0,0)
frame_cnt  out  16  frames completed (optional feature)

Behaviour:
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP. Defaults give 800 and 525.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered and high for the one clk in which div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_en stays high after reset.
- On each clk edge where pix_en is high:
  - x increments.
  - When x==H_TOTAL-1, x wraps to 0 and y increments.
  - When y==V_TOTAL-1 at that same wrap, y wraps to 0.
- All decoded outputs are registered from the next-state counters, so they change on the same edge as x/y and have zero skew relative to them:
  - video_on follows the rule above.
  - h_sync is at HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else at ~HS_POL.
  - v_sync is at VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else at ~VS_POL.
- Strobes: line_start and frame_start are high only for the single clk following the update to x==0 (line_start) or to x==0,y==0 (frame_start), then low.
- Reset (async assert, sync release):
  - div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1.
  - pix_en=0, video_on=0, h_sync=~HS_POL, v_sync=~VS_POL, line_start=0, frame_start=0, frame_cnt=0.
  - The first pixel tick after release moves to (0,0) and raises line_start and frame_start.
- Reset mid-frame returns immediately to the reset state. No partial line is emitted after release.
- No inputs besides clk and rst_n. Timing values that produce XW/YW overflow are illegal; elaboration asserts on them.

Optional Feature:
VGA_FRAME_CNT_EN
- Defined: frame_cnt increments by 1 on every frame_start and wraps 0xFFFF->0x0000. It is used for blink and animation timing.
- Undefined: frame_cnt is tied to 0 and no counter register is built.

Test Plan:
- Release reset with defaults, then run 4 clks -> pix_en pulses on the 4th clk; x=0, y=0, line_start=1, frame_start=1, video_on=1.
- Run to x=655->656 -> h_sync falls to 0 on that edge. At x=752 -> h_sync returns to 1. video_on is 0 from x=640 onward.
- Run 525 lines -> v_sync is 0 exactly for y=490..491. frame_start recurs every 1,680,000 clks (420,000 pixel ticks).
- CLK_DIV=1, HS_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2 -> pix_en is constantly 1, the line repeats every 14 clks, and h_sync is high for x=10..11.
- Assert rst_n low at x=300, y=200 -> all outputs return to reset values asynchronously. After release, the first tick yields (0,0) with frame_start=1.
- With VGA_FRAME_CNT_EN defined, run 3 frames -> frame_cnt reads 1, 2, 3 at successive frame_start strobes. Undefined -> frame_cnt stays 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing core: pixel-clock divider, h/v counters and registered sync/strobe decode.
// Optional frame counter is built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          pix_en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          video_on,
    output logic          h_sync,
    output logic          v_sync,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1 || H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_bad_params
        $error("vga_timing_gen: CLK_DIV < 1 or timing totals overflow XW/YW");
    end

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt_reg;
    logic [DW-1:0] div_cnt_next;
    logic          tick;
    logic [XW-1:0] x_reg;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_reg;
    logic [YW-1:0] y_next;
    logic          line_tick;
    logic          frame_tick;
    logic          pix_en_reg;
    logic          video_on_reg;
    logic          h_sync_reg;
    logic          v_sync_reg;
    logic          line_start_reg;
    logic          frame_start_reg;

    always_comb begin
        tick         = (div_cnt_reg == DIV_LAST);
        div_cnt_next = tick ? '0 : DW'(div_cnt_reg + 1'b1);
        x_next       = x_reg;
        y_next       = y_reg;
        if (tick) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : YW'(y_reg + 1'b1);
            end else begin
                x_next = XW'(x_reg + 1'b1);
            end
        end
        line_tick  = tick && (x_next == '0);
        frame_tick = line_tick && (y_next == '0);
    end

    // Decode from the next-state counters so every output moves on the same edge as x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg     <= '0;
            x_reg           <= X_LAST;
            y_reg           <= Y_LAST;
            pix_en_reg      <= 1'b0;
            video_on_reg    <= 1'b0;
            h_sync_reg      <= ~HS_POL;
            v_sync_reg      <= ~VS_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_cnt_reg     <= div_cnt_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            pix_en_reg      <= tick;
            video_on_reg    <= (x_next < X_ACT) && (y_next < Y_ACT);
            h_sync_reg      <= ((x_next >= HS_START) && (x_next < HS_END)) ? HS_POL : ~HS_POL;
            v_sync_reg      <= ((y_next >= VS_START) && (y_next < VS_END)) ? VS_POL : ~VS_POL;
            line_start_reg  <= line_tick;
            frame_start_reg <= frame_tick;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
        end else if (frame_tick) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`else
    assign frame_cnt = '0;
`endif

    assign pix_en      = pix_en_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign video_on    = video_on_reg;
    assign h_sync      = h_sync_reg;
    assign v_sync      = v_sync_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus a tiny CLK_DIV=1 configuration for full-frame checks.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        d_pix_en, d_video_on, d_h_sync, d_v_sync, d_line_start, d_frame_start;
    logic [9:0]  d_x, d_y;
    logic [15:0] d_frame_cnt;

    logic        s_pix_en, s_video_on, s_h_sync, s_v_sync, s_line_start, s_frame_start;
    logic [3:0]  s_x, s_y;
    logic [15:0] s_frame_cnt;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .pix_en(d_pix_en), .x(d_x), .y(d_y),
        .video_on(d_video_on), .h_sync(d_h_sync), .v_sync(d_v_sync),
        .line_start(d_line_start), .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .XW(4), .YW(4)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en), .x(s_x), .y(s_y),
        .video_on(s_video_on), .h_sync(s_h_sync), .v_sync(s_v_sync),
        .line_start(s_line_start), .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fc_exp(input int frames);
`ifdef VGA_FRAME_CNT_EN
        return frames;
`else
        return 0;
`endif
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_d_pix_en"}, 32'(d_pix_en), 0);
        check({tag, "_d_x"}, 32'(d_x), 799);
        check({tag, "_d_y"}, 32'(d_y), 524);
        check({tag, "_d_video_on"}, 32'(d_video_on), 0);
        check({tag, "_d_h_sync"}, 32'(d_h_sync), 1);
        check({tag, "_d_v_sync"}, 32'(d_v_sync), 1);
        check({tag, "_d_line_start"}, 32'(d_line_start), 0);
        check({tag, "_d_frame_start"}, 32'(d_frame_start), 0);
        check({tag, "_d_frame_cnt"}, 32'(d_frame_cnt), 0);
        check({tag, "_s_x"}, 32'(s_x), 13);
        check({tag, "_s_y"}, 32'(s_y), 9);
        check({tag, "_s_h_sync"}, 32'(s_h_sync), 0);
        check({tag, "_s_v_sync"}, 32'(s_v_sync), 1);
        check({tag, "_s_pix_en"}, 32'(s_pix_en), 0);
    endtask

    initial begin
        int k, sx, sy;
        repeat (3) step();
        check_reset_state("rst");

        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 1; n <= 7604; n++) begin
            step();
            // Tiny config ticks every clk: 14-pixel lines, 10-line frames, 140-clk frame period.
            if (n <= 300) begin
                k  = n - 1;
                sx = k % 14;
                sy = (k / 14) % 10;
                check("s_pix_en", 32'(s_pix_en), 1);
                check("s_x", 32'(s_x), 32'(sx));
                check("s_y", 32'(s_y), 32'(sy));
                check("s_video_on", 32'(s_video_on), 32'(sx < 8 && sy < 6));
                check("s_h_sync", 32'(s_h_sync), 32'(sx >= 10 && sx < 12));
                check("s_v_sync", 32'(s_v_sync), 32'(!(sy >= 7 && sy < 9)));
                check("s_line_start", 32'(s_line_start), 32'(sx == 0));
                check("s_frame_start", 32'(s_frame_start), 32'(sx == 0 && sy == 0));
                check("s_frame_cnt", 32'(s_frame_cnt), 32'(fc_exp(k / 140 + 1)));
            end
            if (n == 3) begin
                check("d3_pix_en", 32'(d_pix_en), 0);
                check("d3_x", 32'(d_x), 799);
                check("d3_y", 32'(d_y), 524);
                check("d3_line_start", 32'(d_line_start), 0);
            end
            if (n == 4) begin
                check("d4_pix_en", 32'(d_pix_en), 1);
                check("d4_x", 32'(d_x), 0);
                check("d4_y", 32'(d_y), 0);
                check("d4_line_start", 32'(d_line_start), 1);
                check("d4_frame_start", 32'(d_frame_start), 1);
                check("d4_video_on", 32'(d_video_on), 1);
                check("d4_h_sync", 32'(d_h_sync), 1);
                check("d4_v_sync", 32'(d_v_sync), 1);
                check("d4_frame_cnt", 32'(d_frame_cnt), 32'(fc_exp(1)));
            end
            if (n == 5) begin
                check("d5_pix_en", 32'(d_pix_en), 0);
                check("d5_x", 32'(d_x), 0);
                check("d5_line_start", 32'(d_line_start), 0);
                check("d5_frame_start", 32'(d_frame_start), 0);
            end
            if (n == 2560) begin
                check("d_x639", 32'(d_x), 639);
                check("d_von639", 32'(d_video_on), 1);
            end
            if (n == 2564) begin
                check("d_x640", 32'(d_x), 640);
                check("d_von640", 32'(d_video_on), 0);
            end
            if (n == 2627) begin
                check("d_x655", 32'(d_x), 655);
                check("d_hs655", 32'(d_h_sync), 1);
            end
            if (n == 2628) begin
                check("d_x656", 32'(d_x), 656);
                check("d_hs656", 32'(d_h_sync), 0);
            end
            if (n == 3011) begin
                check("d_x751", 32'(d_x), 751);
                check("d_hs751", 32'(d_h_sync), 0);
            end
            if (n == 3012) begin
                check("d_x752", 32'(d_x), 752);
                check("d_hs752", 32'(d_h_sync), 1);
            end
            if (n == 3200) begin
                check("d_x799", 32'(d_x), 799);
                check("d_y799", 32'(d_y), 0);
                check("d_ls799", 32'(d_line_start), 0);
            end
            if (n == 3204) begin
                check("d_wrap_x", 32'(d_x), 0);
                check("d_wrap_y", 32'(d_y), 1);
                check("d_wrap_ls", 32'(d_line_start), 1);
                check("d_wrap_fs", 32'(d_frame_start), 0);
                check("d_wrap_von", 32'(d_video_on), 1);
                check("d_wrap_vs", 32'(d_v_sync), 1);
            end
            if (n == 3205) begin
                check("d_wrap_ls_low", 32'(d_line_start), 0);
            end
        end
        check("d_mid_x", 32'(d_x), 300);
        check("d_mid_y", 32'(d_y), 2);
        check("d_mid_von", 32'(d_video_on), 1);

        // Mid-frame reset must clear outputs without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("rel3_d_pix_en", 32'(d_pix_en), 0);
        check("rel3_d_x", 32'(d_x), 799);
        check("rel3_d_frame_start", 32'(d_frame_start), 0);
        step();
        check("rel4_d_x", 32'(d_x), 0);
        check("rel4_d_y", 32'(d_y), 0);
        check("rel4_d_frame_start", 32'(d_frame_start), 1);
        check("rel4_d_line_start", 32'(d_line_start), 1);
        check("rel4_d_frame_cnt", 32'(d_frame_cnt), 32'(fc_exp(1)));
        check("rel4_s_x", 32'(s_x), 3);
        check("rel4_s_y", 32'(s_y), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
